// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register-bank write path: default widths,
// requester index assignments and the grant-ID width helper.
package proc_pkg;

    localparam int REG_DATA_W  = 8;
    localparam int REG_ADDR_W  = 3;
    localparam int NUM_REQ_DEF = 4;

    // Fixed requester slots on the write port
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;
    localparam int REQ_DBG  = 3;

    // Width of a requester index; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_ID_W = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side request bus and register-bank write port of the arbiter.
interface reg_write_arbiter_if
    import proc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
);
    localparam int ID_W = id_width(NUM_REQ);

    logic                        arb_en;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          gnt;
    logic [ID_W-1:0]             gnt_id;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_W-1:0]           wr_data;

    // Requesters (and the bank) see the arbiter from this side
    modport master (
        output arb_en, req, req_addr, req_data,
        input  gnt, gnt_id, wr_en, wr_addr, wr_data
    );

    // The arbiter itself
    modport slave (
        input  arb_en, req, req_addr, req_data,
        output gnt, gnt_id, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_priority_pick
    import proc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_eff,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] req_rot;
    logic [ID_W-1:0]    pick_rot;

    // Rotate requests so the highest-priority slot lands at bit 0
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rot[i] = req_eff[(i + int'(rr_ptr)) % NUM_REQ];
        end
    end

    // Lowest set bit of the rotated vector wins
    always_comb begin
        pick_rot = '0;
        valid    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_rot = ID_W'(i);
                valid    = 1'b1;
            end
        end
    end

    // Undo the rotation to get the absolute requester index
    always_comb begin
        winner = ID_W'((int'(pick_rot) + int'(rr_ptr)) % NUM_REQ);
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port. All outputs
// are registered so each granted write is a clean one-cycle strobe.
module reg_write_arbiter
    import proc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                async_reset,
    reg_write_arbiter_if.slave  bus
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [ID_W-1:0]    gnt_id_q,  gnt_id_d;
    logic               wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ID_W-1:0]    rr_ptr_q,  rr_ptr_d;

    logic [NUM_REQ-1:0] req_eff;
    logic [ID_W-1:0]    winner;
    logic               winner_vld;

    // A requester holding a grant this cycle cannot win the next edge
    assign req_eff = bus.req & ~gnt_q;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_eff (req_eff),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .valid   (winner_vld)
    );

    // Next grant, captured write and pointer advance; idle edges hold id/addr/data/pointer
    always_comb begin
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        gnt_id_d  = gnt_id_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (bus.arb_en && winner_vld) begin
            gnt_d     = NUM_REQ'(1) << winner;
            wr_en_d   = 1'b1;
            gnt_id_d  = winner;
            wr_addr_d = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
            wr_data_d = bus.req_data[int'(winner)*DATA_W +: DATA_W];
            rr_ptr_d  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // Output and pointer registers; reset drops any in-flight strobe at once
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed vector bench for reg_write_arbiter (4 requesters, 8-bit data).
module tb_reg_write_arbiter;
    import proc_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk;
    logic async_reset;

    reg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [7:0] d0, d1, d2, d3;
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic       e_wr;
        logic [2:0] e_addr;
        logic [7:0] e_data;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] req,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        bus.arb_en   = en;
        bus.req      = req;
        bus.req_data = {d3, d2, d1, d0};
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic wr, input logic [2:0] a, input logic [7:0] d);
        chk({tag, ".gnt"},     32'(bus.gnt),     32'(g));
        chk({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(id));
        chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(wr));
        chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(a));
        chk({tag, ".wr_data"}, 32'(bus.wr_data), 32'(d));
    endtask

    initial begin
        // Requester addresses: r0=3, r1=5, r2=6, r3=1
        vecs[0]  = '{1'b1, 4'b0001, 8'hA5, 8'h22, 8'h33, 8'h44, 4'b0001, 2'd0, 1'b1, 3'd3, 8'hA5};
        vecs[1]  = '{1'b1, 4'b0001, 8'hA5, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd0, 1'b0, 3'd3, 8'hA5};
        vecs[2]  = '{1'b1, 4'b0001, 8'hA5, 8'h22, 8'h33, 8'h44, 4'b0001, 2'd0, 1'b1, 3'd3, 8'hA5};
        vecs[3]  = '{1'b1, 4'b0001, 8'hA5, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd0, 1'b0, 3'd3, 8'hA5};
        vecs[4]  = '{1'b1, 4'b1000, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 2'd3, 1'b1, 3'd1, 8'h44};
        vecs[5]  = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 2'd0, 1'b1, 3'd3, 8'h11};
        vecs[6]  = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0010, 2'd1, 1'b1, 3'd5, 8'h22};
        vecs[7]  = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100, 2'd2, 1'b1, 3'd6, 8'h33};
        vecs[8]  = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 2'd3, 1'b1, 3'd1, 8'h44};
        vecs[9]  = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 2'd0, 1'b1, 3'd3, 8'h11};
        vecs[10] = '{1'b1, 4'b0100, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100, 2'd2, 1'b1, 3'd6, 8'h33};
        vecs[11] = '{1'b1, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 2'd0, 1'b1, 3'd3, 8'h11};
        vecs[12] = '{1'b1, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100, 2'd2, 1'b1, 3'd6, 8'h33};
        vecs[13] = '{1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd2, 1'b0, 3'd6, 8'h33};
        vecs[14] = '{1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd2, 1'b0, 3'd6, 8'h33};
        vecs[15] = '{1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd2, 1'b0, 3'd6, 8'h33};
        vecs[16] = '{1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 2'd3, 1'b1, 3'd1, 8'h44};
        vecs[17] = '{1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 2'd3, 1'b0, 3'd1, 8'h44};
        vecs[18] = '{1'b1, 4'b0010, 8'h11, 8'h77, 8'h33, 8'h44, 4'b0010, 2'd1, 1'b1, 3'd5, 8'h77};
        vecs[19] = '{1'b1, 4'b0010, 8'h11, 8'h99, 8'h33, 8'h44, 4'b0000, 2'd1, 1'b0, 3'd5, 8'h77};

        async_reset  = 1'b1;
        bus.arb_en   = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_addr = '0;
        bus.req_addr[REQ_ALU*AW  +: AW] = 3'd3;
        bus.req_addr[REQ_LOAD*AW +: AW] = 3'd5;
        bus.req_addr[REQ_IMM*AW  +: AW] = 3'd6;
        bus.req_addr[REQ_DBG*AW  +: AW] = 3'd1;

        // Reset with requests active across an edge: outputs stay cleared
        #1 async_reset = 1'b0;
        drive(1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        #6;
        chk_outs("reset", 4'b0000, 2'd0, 1'b0, 3'd0, 8'h00);
        async_reset = 1'b1;
        drive(1'b1, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44);

        // Table: single writer, full contention, wrap, enable gating, data capture
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_id,
                     vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_data);
        end

        // Reset mid-contention with rr_ptr=2: grant to 2 is live, reset kills it
        drive(1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        step();
        chk("midrst.pre_gnt", 32'(bus.gnt), 32'(4'b0100));
        chk("midrst.pre_wr",  32'(bus.wr_en), 32'd1);
        #3 async_reset = 1'b0;
        #1;
        chk_outs("midrst.async", 4'b0000, 2'd0, 1'b0, 3'd0, 8'h00);
        step();
        chk("midrst.held_wr", 32'(bus.wr_en), 32'd0);
        #3 async_reset = 1'b1;
        step();
        chk_outs("midrst.first", 4'b0001, 2'd0, 1'b1, 3'd3, 8'h11);
        step();
        chk_outs("midrst.second", 4'b0010, 2'd1, 1'b1, 3'd5, 8'h22);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the processor's 8-bit register bank between NUM_REQ requesters (e.g. ALU writeback, load unit, immediate loader, debug).
- Sits between the requesters and the register instances' d/load inputs.
- Outputs are registered, so each granted write reaches the bank as a clean one-cycle strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, register data width.
- ADDR_W, 3, register select width (8 registers).

Ports:
- clk  input  1  system clock, rising edge.
- async_reset  input  1  asynchronous, active-low reset.
- arb_en  input  1  when 0, no new grants are issued.
- req  input  NUM_REQ  per-requester write request, level.
- req_addr  input  NUM_REQ*ADDR_W  flattened target register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  flattened write data; requester i uses slice [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
- gnt_id  output  clog2(NUM_REQ)  index of the current grant.
- wr_en  output  1  register bank write strobe.
- wr_addr  output  ADDR_W  register bank write address.
- wr_data  output  DATA_W  register bank write data.

Behaviour:
- Reset
  - async_reset=0 forces the following immediately, independent of clk: gnt=0, gnt_id=0, wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0.
  - Reset asserted mid-grant kills the strobe in the same cycle; the interrupted write is dropped and is not replayed.
  - After release, the first possible grant is at the first clk rising edge where async_reset=1.
- Request masking
  - Effective request: req_eff = req & ~gnt.
  - A requester being granted this cycle cannot win the next edge.
  - A continuously asserted single requester is therefore granted every other cycle.
- Selection (combinational)
  - Winner = first index i with req_eff[i]=1, scanning rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1 (wrap modulo NUM_REQ).
- Each rising edge, with arb_en=1 and req_eff != 0 (winner w):
  - gnt <= one-hot(w); gnt_id <= w; wr_en <= 1.
  - wr_addr <= req_addr slice w; wr_data <= req_data slice w.
  - rr_ptr <= (w+1) mod NUM_REQ; this wraps from NUM_REQ-1 to 0.
- Each rising edge, with arb_en=0 or req_eff=0:
  - gnt <= 0; wr_en <= 0.
  - gnt_id, wr_addr, wr_data and rr_ptr hold their values.
- Latency and handshake
  - Request to strobe latency is 1 clk.
  - Requester protocol: hold req, addr and data stable until it samples gnt[i]=1, then deassert req or present the next write.
  - The arbiter captures data at the granting edge, so the requester may change data in the gnt cycle.
- arb_en falling while a grant is high does not cancel that grant; it blocks only subsequent edges.
- Throughput: at most one write per cycle. Full throughput is reached whenever 2 or more requesters are active.
- Invariants
  - gnt is always zero or one-hot.
  - wr_en == |gnt.
  - gnt_id matches gnt whenever wr_en=1.

Decomposition:
- Shared package (proc_pkg) holds:
  - DATA_W=8 and REG_ADDR_W=3 defaults;
  - the requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_IMM=2, REQ_DBG=3);
  - a clog2-based ID width constant.
- One sub-module, rr_priority_pick: combinational rotate, then priority-encode, then rotate back.
  - Inputs: req_eff, rr_ptr.
  - Outputs: winner index, valid.
  - Kept separate so it can be unit-tested alone.
- Top level holds the rr_ptr register, output registers and the data/address mux.

Test Plan:
1. Reset: drive async_reset=0 mid-cycle while wr_en=1 -> all outputs 0 before the next edge; after release with req=0001, grant goes to requester 0.
2. Single write: req=0001, addr0=3'd3, data0=8'hA5, one edge -> gnt=0001, gnt_id=0, wr_en=1, wr_addr=3, wr_data=A5; req held high -> gnt pattern 0001,0000,0001,0000.
3. Full contention: req=1111 held from rr_ptr=0 -> gnt sequence 0001,0010,0100,1000,0001, with wr_en=1 every cycle and wr_data following each requester's data (11,22,33,44,11).
4. Wrap-around: set rr_ptr=3 by granting requester 2, then req=0101 -> next grant requester 0 (gnt_id=0, rr_ptr becomes 1), then requester 2.
5. Enable gating: arb_en=0 with req=1111 for 3 cycles -> gnt=0, wr_en=0, rr_ptr and wr_data unchanged; arb_en=1 -> grant resumes at the held rr_ptr.
6. Reset mid-contention: req=1111 and rr_ptr=2, pulse async_reset low -> wr_en drops immediately; after release the first grant goes to requester 0.
